game_sprite_motion_ctrl: RTL and testbench
==========================================

Name: game_sprite_motion_ctrl

Overview:
Sequencer for one sprite display pipeline. It loads a launch position, steps the sprite by a signed velocity once every STRIDE frames, and verifies the new position against the display pipeline's registered sprite_within_screen after the pipeline latency. It retires the sprite (gone pulse) when it leaves the screen. It sits between game logic (launch/abort, velocity) and the sprite display block (drives its sprite_x/sprite_y, consumes its sprite_within_screen).

Parameters:
DX_WIDTH, 4, width of signed x velocity (two's complement)
DY_WIDTH, 4, width of signed y velocity (two's complement)
STRIDE, 1, frames per position step; legal range 1..255
CHECK_DELAY, 2, cycles from a sprite_x/sprite_y change to a valid sprite_within_screen; legal range 1..15

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous reset, active low
launch  in  1  pulse; start a new flight (ignored unless IDLE)
abort  in  1  level; force return to IDLE, highest priority
start_x  in  `X_WIDTH  launch x, sampled with launch
start_y  in  `Y_WIDTH  launch y, sampled with launch
dx  in  DX_WIDTH  signed x step, sampled with launch
dy  in  DY_WIDTH  signed y step, sampled with launch
frame_start  in  1  one-cycle pulse per frame (vertical blank)
sprite_within_screen  in  1  from display pipeline, CHECK_DELAY cycles behind sprite_x/y
sprite_x  out  `X_WIDTH  registered sprite position to display pipeline
sprite_y  out  `Y_WIDTH  registered sprite position to display pipeline
sprite_visible  out  1  registered; gate for display rgb_en
running  out  1  registered; high while not IDLE
sprite_gone  out  1  one-cycle registered pulse when sprite retires off-screen

Behaviour:
- Reset (reset_n=0, async): state IDLE; sprite_x=0, sprite_y=0, sprite_visible=0, running=0, sprite_gone=0; delay and frame counters 0; latched dx/dy 0.
- All outputs registered; sprite_gone defaults to 0 every cycle unless set below.
- States: IDLE, CHECK, WAIT_FRAME.
- IDLE: launch=1 -> sprite_x<=start_x, sprite_y<=start_y, latch dx/dy, delay_cnt<=CHECK_DELAY, running<=1, sprite_visible<=0 -> CHECK. frame_start in IDLE ignored.
- CHECK: delay_cnt decrements each cycle; in the cycle delay_cnt==0, sample sprite_within_screen:
  - 1 -> sprite_visible<=1, frame_cnt<=0 -> WAIT_FRAME.
  - 0 -> sprite_visible<=0, running<=0, sprite_gone<=1 -> IDLE.
  - Sample occurs exactly CHECK_DELAY+1 edges after the position-update edge.
- WAIT_FRAME: on frame_start: if frame_cnt==STRIDE-1 -> sprite_x<=sprite_x+sext(dx), sprite_y<=sprite_y+sext(dy), frame_cnt<=0, delay_cnt<=CHECK_DELAY -> CHECK (sprite_visible stays 1); else frame_cnt<=frame_cnt+1. No frame_start -> hold.
- frame_start arriving in CHECK is dropped; it is neither queued nor counted.
- Arithmetic: velocities sign-extended to `X_WIDTH/`Y_WIDTH; sums wrap modulo 2^`X_WIDTH / 2^`Y_WIDTH, with no saturation. Wrap produces an off-screen value that the display pipeline reports as not within screen, which retires the sprite.
- dx=dy=0: sprite stays in place indefinitely; the check still runs each step.
- abort=1 in any state: next edge -> IDLE, sprite_visible<=0, running<=0, sprite_gone stays 0, sprite_x/y hold. abort overrides launch in the same cycle.
- launch while running (no abort): ignored; latched values are unchanged.
- reset_n deassertion mid-flight returns to the reset values above; no gone pulse is generated.

Test Plan:
- Reset then launch start=(100,200), dx=+3, dy=-2, STRIDE=1, bench model within=(x<=639&&y<=479) delayed 2 -> sprite_visible=1 three edges after launch edge; after each frame_start position (103,198),(106,196)...
- Launch x=636, dx=+2, y=10, dy=0 -> steps 638, 640; at 640 sprite_gone single-cycle pulse, running=0, visible=0, sprite_x holds 640.
- Launch off-screen (700,0) -> no visible, sprite_gone pulses exactly CHECK_DELAY+1 edges after launch edge.
- STRIDE=3, start (0,0), dx=+1: position changes only on every 3rd frame_start; frame_start pulses during CHECK dropped (frame_cnt unchanged).
- Launch (2,5), dx=-4 -> x wraps to 1022, sprite_gone pulses; repeat launch while running -> ignored, sprite_x unchanged.
- abort in WAIT_FRAME at (50,50) -> IDLE next edge, visible=0, no gone pulse; launch and abort asserted together -> stays IDLE; reset_n asserted mid-CHECK -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/game_sprite_motion_ctrl_if.sv
//==============================================================================
// game_sprite_motion_ctrl_if : game-logic / display-pipeline bundle for the sprite motion sequencer
// Revision 1.0
//==============================================================================
`default_nettype none

`ifndef X_WIDTH
`define X_WIDTH 10
`endif
`ifndef Y_WIDTH
`define Y_WIDTH 10
`endif

interface game_sprite_motion_ctrl_if #(
  parameter int DX_WIDTH = 4,
  parameter int DY_WIDTH = 4
);
  logic                  launch;
  logic                  abort;
  logic [`X_WIDTH-1:0]   start_x;
  logic [`Y_WIDTH-1:0]   start_y;
  logic [DX_WIDTH-1:0]   dx;
  logic [DY_WIDTH-1:0]   dy;
  logic                  frame_start;
  logic                  sprite_within_screen;
  logic [`X_WIDTH-1:0]   sprite_x;
  logic [`Y_WIDTH-1:0]   sprite_y;
  logic                  sprite_visible;
  logic                  running;
  logic                  sprite_gone;

  modport master (
    output launch, abort, start_x, start_y, dx, dy, frame_start, sprite_within_screen,
    input  sprite_x, sprite_y, sprite_visible, running, sprite_gone
  );

  modport slave (
    input  launch, abort, start_x, start_y, dx, dy, frame_start, sprite_within_screen,
    output sprite_x, sprite_y, sprite_visible, running, sprite_gone
  );
endinterface

`default_nettype wire

// File: rtl/game_sprite_motion_ctrl.sv
//==============================================================================
// game_sprite_motion_ctrl : launches, steps and retires one sprite, checking each position on-screen
// Revision 1.0
//==============================================================================
`default_nettype none

`ifndef X_WIDTH
`define X_WIDTH 10
`endif
`ifndef Y_WIDTH
`define Y_WIDTH 10
`endif

module game_sprite_motion_ctrl #(
  parameter int DX_WIDTH    = 4,
  parameter int DY_WIDTH    = 4,
  parameter int STRIDE      = 1,
  parameter int CHECK_DELAY = 2
) (
  input  wire                      clk,
  input  wire                      reset_n,
  game_sprite_motion_ctrl_if.slave bus
);

  localparam int         XW         = `X_WIDTH;
  localparam int         YW         = `Y_WIDTH;
  localparam logic [3:0] DELAY_INIT = 4'(CHECK_DELAY);
  localparam logic [7:0] FRAME_LAST = 8'(STRIDE - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CHECK      = 2'd1,
    WAIT_FRAME = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [XW-1:0]       pos_x, pos_x_next;
  logic [YW-1:0]       pos_y, pos_y_next;
  logic [DX_WIDTH-1:0] vel_x, vel_x_next;
  logic [DY_WIDTH-1:0] vel_y, vel_y_next;
  logic [3:0]          delay_cnt, delay_cnt_next;
  logic [7:0]          frame_cnt, frame_cnt_next;
  logic                visible, visible_next;
  logic                running, running_next;
  logic                gone, gone_next;
  logic [XW-1:0]       step_x;
  logic [YW-1:0]       step_y;

  // Sign-extended velocities; the sums wrap so an overflow lands off-screen and retires the sprite.
  assign step_x = XW'($signed(vel_x));
  assign step_y = YW'($signed(vel_y));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pos_x     <= '0;
      pos_y     <= '0;
      vel_x     <= '0;
      vel_y     <= '0;
      delay_cnt <= '0;
      frame_cnt <= '0;
      visible   <= 1'b0;
      running   <= 1'b0;
      gone      <= 1'b0;
    end else begin
      state     <= state_next;
      pos_x     <= pos_x_next;
      pos_y     <= pos_y_next;
      vel_x     <= vel_x_next;
      vel_y     <= vel_y_next;
      delay_cnt <= delay_cnt_next;
      frame_cnt <= frame_cnt_next;
      visible   <= visible_next;
      running   <= running_next;
      gone      <= gone_next;
    end
  end

  always_comb begin
    state_next     = state;
    pos_x_next     = pos_x;
    pos_y_next     = pos_y;
    vel_x_next     = vel_x;
    vel_y_next     = vel_y;
    delay_cnt_next = delay_cnt;
    frame_cnt_next = frame_cnt;
    visible_next   = visible;
    running_next   = running;
    gone_next      = 1'b0;

    if (bus.abort) begin
      state_next   = IDLE;
      visible_next = 1'b0;
      running_next = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.launch) begin
            pos_x_next     = bus.start_x;
            pos_y_next     = bus.start_y;
            vel_x_next     = bus.dx;
            vel_y_next     = bus.dy;
            delay_cnt_next = DELAY_INIT;
            running_next   = 1'b1;
            visible_next   = 1'b0;
            state_next     = CHECK;
          end
        end

        // frame_start is deliberately not observed here: pulses during a check are dropped.
        CHECK: begin
          if (delay_cnt == 4'd0) begin
            if (bus.sprite_within_screen) begin
              visible_next   = 1'b1;
              frame_cnt_next = 8'd0;
              state_next     = WAIT_FRAME;
            end else begin
              visible_next = 1'b0;
              running_next = 1'b0;
              gone_next    = 1'b1;
              state_next   = IDLE;
            end
          end else begin
            delay_cnt_next = delay_cnt - 4'd1;
          end
        end

        WAIT_FRAME: begin
          if (bus.frame_start) begin
            if (frame_cnt == FRAME_LAST) begin
              pos_x_next     = pos_x + step_x;
              pos_y_next     = pos_y + step_y;
              frame_cnt_next = 8'd0;
              delay_cnt_next = DELAY_INIT;
              state_next     = CHECK;
            end else begin
              frame_cnt_next = frame_cnt + 8'd1;
            end
          end
        end

        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.sprite_x       = pos_x;
  assign bus.sprite_y       = pos_y;
  assign bus.sprite_visible = visible;
  assign bus.running        = running;
  assign bus.sprite_gone    = gone;

endmodule

`default_nettype wire

// File: tb/tb_game_sprite_motion_ctrl.sv
//==============================================================================
// tb_game_sprite_motion_ctrl : scenario bench for the sprite motion sequencer (STRIDE 1 and 3)
// Revision 1.0
//==============================================================================
`default_nettype none

`ifndef X_WIDTH
`define X_WIDTH 10
`endif
`ifndef Y_WIDTH
`define Y_WIDTH 10
`endif

module tb_game_sprite_motion_ctrl;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } pos_t;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  pos_t exp_q[$];
  pos_t got;
  pos_t want;

  always #5 clk = ~clk;

  game_sprite_motion_ctrl_if #(.DX_WIDTH(4), .DY_WIDTH(4)) s1();
  game_sprite_motion_ctrl_if #(.DX_WIDTH(4), .DY_WIDTH(4)) s3();

  game_sprite_motion_ctrl #(.DX_WIDTH(4), .DY_WIDTH(4), .STRIDE(1), .CHECK_DELAY(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(s1.slave)
  );
  game_sprite_motion_ctrl #(.DX_WIDTH(4), .DY_WIDTH(4), .STRIDE(3), .CHECK_DELAY(2)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(s3.slave)
  );

  // Display pipeline stand-in: registered on-screen test, two cycles behind the position.
  logic [1:0] pipe1, pipe3;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe1 <= 2'b00;
      pipe3 <= 2'b00;
    end else begin
      pipe1 <= {pipe1[0], (s1.sprite_x <= 10'd639) && (s1.sprite_y <= 10'd479)};
      pipe3 <= {pipe3[0], (s3.sprite_x <= 10'd639) && (s3.sprite_y <= 10'd479)};
    end
  end
  assign s1.sprite_within_screen = pipe1[1];
  assign s3.sprite_within_screen = pipe3[1];

  function automatic logic [22:0] snap1();
    return {s1.sprite_x, s1.sprite_y, s1.sprite_visible, s1.running, s1.sprite_gone};
  endfunction

  function automatic logic [22:0] snap3();
    return {s3.sprite_x, s3.sprite_y, s3.sprite_visible, s3.running, s3.sprite_gone};
  endfunction

  function automatic logic [22:0] mk(input int x, input int y, input bit v, input bit r, input bit g);
    return {10'(x), 10'(y), v, r, g};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch1(input int x, input int y, input logic [3:0] vx, input logic [3:0] vy);
    s1.start_x = 10'(x); s1.start_y = 10'(y); s1.dx = vx; s1.dy = vy;
    s1.launch = 1'b1;
    tick();
    s1.launch = 1'b0;
  endtask

  task automatic launch3(input int x, input int y, input logic [3:0] vx, input logic [3:0] vy);
    s3.start_x = 10'(x); s3.start_y = 10'(y); s3.dx = vx; s3.dy = vy;
    s3.launch = 1'b1;
    tick();
    s3.launch = 1'b0;
  endtask

  task automatic frame1();
    s1.frame_start = 1'b1;
    tick();
    s1.frame_start = 1'b0;
  endtask

  task automatic frame3();
    s3.frame_start = 1'b1;
    tick();
    s3.frame_start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    s1.launch = 0; s1.abort = 0; s1.frame_start = 0; s1.start_x = 0; s1.start_y = 0; s1.dx = 0; s1.dy = 0;
    s3.launch = 0; s3.abort = 0; s3.frame_start = 0; s3.start_x = 0; s3.start_y = 0; s3.dx = 0; s3.dy = 0;
    repeat (2) tick();
    checks++;
    if (snap1() !== 23'd0 || snap3() !== 23'd0) begin
      errors++;
      $display("FAIL reset_state: got %h / %h required 0", snap1(), snap3());
    end
    reset_n = 1'b1;
    tick();
    frame1();
    checks++;
    if (snap1() !== 23'd0) begin
      errors++;
      $display("FAIL idle_frame_ignored: got %h required 0", snap1());
    end
  endtask

  task automatic test_flight();
    launch1(100, 200, 4'd3, 4'hE);
    checks++;
    if (snap1() !== mk(100, 200, 0, 1, 0)) begin
      errors++;
      $display("FAIL launch_load: got %h required %h", snap1(), mk(100, 200, 0, 1, 0));
    end
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++;
      if (s1.sprite_visible !== (e == 3)) begin
        errors++;
        $display("FAIL visible_latency edge %0d: got %b required %b", e, s1.sprite_visible, e == 3);
      end
    end
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back('{x: 10'(100 + 3 * k), y: 10'(200 - 2 * k)});
      frame1();
      got = '{x: s1.sprite_x, y: s1.sprite_y};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL flight_step %0d: scoreboard empty", k);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL flight_step %0d: got (%0d,%0d) required (%0d,%0d)", k, got.x, got.y, want.x, want.y);
        end
      end
      repeat (3) tick();
      checks++;
      if ({s1.sprite_visible, s1.running, s1.sprite_gone} !== 3'b110) begin
        errors++;
        $display("FAIL flight_check %0d: got vrg=%b required 110", k, {s1.sprite_visible, s1.running, s1.sprite_gone});
      end
    end
    s1.abort = 1'b1;
    tick();
    s1.abort = 1'b0;
  endtask

  task automatic test_exit_right();
    launch1(636, 10, 4'd2, 4'd0);
    repeat (3) tick();
    checks++;
    if (snap1() !== mk(636, 10, 1, 1, 0)) begin
      errors++;
      $display("FAIL exit_launch: got %h required %h", snap1(), mk(636, 10, 1, 1, 0));
    end
    for (int k = 1; k <= 2; k++) begin
      exp_q.push_back('{x: 10'(636 + 2 * k), y: 10'd10});
      frame1();
      got = '{x: s1.sprite_x, y: s1.sprite_y};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL exit_step %0d: got (%0d,%0d) required (%0d,%0d)", k, got.x, got.y, want.x, want.y);
      end
      repeat (2) tick();
      checks++;
      if (snap1() !== mk(want.x, 10, 1, 1, 0)) begin
        errors++;
        $display("FAIL exit_pre_sample %0d: got %h required %h", k, snap1(), mk(want.x, 10, 1, 1, 0));
      end
      if (k == 1) tick();
    end
    tick();
    checks++;
    if (snap1() !== mk(640, 10, 0, 0, 1)) begin
      errors++;
      $display("FAIL exit_gone: got %h required %h", snap1(), mk(640, 10, 0, 0, 1));
    end
    tick();
    checks++;
    if (snap1() !== mk(640, 10, 0, 0, 0)) begin
      errors++;
      $display("FAIL exit_gone_single: got %h required %h", snap1(), mk(640, 10, 0, 0, 0));
    end
  endtask

  task automatic test_offscreen_launch();
    launch1(700, 0, 4'd0, 4'd0);
    repeat (2) tick();
    checks++;
    if (snap1() !== mk(700, 0, 0, 1, 0)) begin
      errors++;
      $display("FAIL offscreen_early: got %h required %h", snap1(), mk(700, 0, 0, 1, 0));
    end
    tick();
    checks++;
    if (snap1() !== mk(700, 0, 0, 0, 1)) begin
      errors++;
      $display("FAIL offscreen_gone: got %h required %h", snap1(), mk(700, 0, 0, 0, 1));
    end
    tick();
    checks++;
    if (s1.sprite_gone !== 1'b0) begin
      errors++;
      $display("FAIL offscreen_gone_single: got %b required 0", s1.sprite_gone);
    end
  endtask

  task automatic test_stride();
    int fc;
    int px;
    fc = 0;
    px = 0;
    launch3(0, 0, 4'd1, 4'd0);
    repeat (3) tick();
    checks++;
    if (snap3() !== mk(0, 0, 1, 1, 0)) begin
      errors++;
      $display("FAIL stride_launch: got %h required %h", snap3(), mk(0, 0, 1, 1, 0));
    end
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 3; i++) begin
        fc++;
        if (fc == 3) begin
          fc = 0;
          px++;
        end
        exp_q.push_back('{x: 10'(px), y: 10'd0});
        frame3();
        got = '{x: s3.sprite_x, y: s3.sprite_y};
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL stride_frame p%0d i%0d: got (%0d,%0d) required (%0d,%0d)", pass, i, got.x, got.y, want.x, want.y);
        end
      end
      // this pulse lands while the new position is being checked and must be lost
      frame3();
      repeat (2) tick();
      checks++;
      if (snap3() !== mk(px, 0, 1, 1, 0)) begin
        errors++;
        $display("FAIL stride_drop p%0d: got %h required %h", pass, snap3(), mk(px, 0, 1, 1, 0));
      end
    end
    s3.abort = 1'b1;
    tick();
    s3.abort = 1'b0;
  endtask

  task automatic test_wrap_and_relaunch();
    launch1(2, 5, 4'hC, 4'd0);
    repeat (3) tick();
    s1.start_x = 10'd300; s1.start_y = 10'd300; s1.dx = 4'd1; s1.dy = 4'd1;
    s1.launch = 1'b1;
    tick();
    s1.launch = 1'b0;
    checks++;
    if (snap1() !== mk(2, 5, 1, 1, 0)) begin
      errors++;
      $display("FAIL relaunch_ignored: got %h required %h", snap1(), mk(2, 5, 1, 1, 0));
    end
    exp_q.push_back('{x: 10'd1022, y: 10'd5});
    frame1();
    got = '{x: s1.sprite_x, y: s1.sprite_y};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL wrap_step: got (%0d,%0d) required (%0d,%0d)", got.x, got.y, want.x, want.y);
    end
    repeat (3) tick();
    checks++;
    if (snap1() !== mk(1022, 5, 0, 0, 1)) begin
      errors++;
      $display("FAIL wrap_gone: got %h required %h", snap1(), mk(1022, 5, 0, 0, 1));
    end
  endtask

  task automatic test_abort();
    bit seen_gone;
    launch1(50, 50, 4'd0, 4'd0);
    repeat (3) tick();
    frame1();
    repeat (3) tick();
    checks++;
    if (snap1() !== mk(50, 50, 1, 1, 0)) begin
      errors++;
      $display("FAIL zero_velocity_hold: got %h required %h", snap1(), mk(50, 50, 1, 1, 0));
    end
    s1.abort = 1'b1;
    tick();
    s1.abort = 1'b0;
    checks++;
    if (snap1() !== mk(50, 50, 0, 0, 0)) begin
      errors++;
      $display("FAIL abort_idle: got %h required %h", snap1(), mk(50, 50, 0, 0, 0));
    end
    seen_gone = 1'b0;
    repeat (4) begin
      tick();
      seen_gone |= s1.sprite_gone;
    end
    checks++;
    if (seen_gone !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_gone: got gone=%b required 0", seen_gone);
    end
    s1.start_x = 10'd10; s1.start_y = 10'd10;
    s1.launch = 1'b1;
    s1.abort  = 1'b1;
    tick();
    s1.launch = 1'b0;
    s1.abort  = 1'b0;
    repeat (3) tick();
    checks++;
    if (snap1() !== mk(50, 50, 0, 0, 0)) begin
      errors++;
      $display("FAIL abort_over_launch: got %h required %h", snap1(), mk(50, 50, 0, 0, 0));
    end
  endtask

  task automatic test_reset_mid_flight();
    launch1(100, 100, 4'd1, 4'd1);
    tick();
    checks++;
    if (s1.running !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_running: got %b required 1", s1.running);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (snap1() !== 23'd0 || snap3() !== 23'd0) begin
      errors++;
      $display("FAIL reset_async: got %h / %h required 0", snap1(), snap3());
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) tick();
    checks++;
    if (snap1() !== 23'd0) begin
      errors++;
      $display("FAIL reset_release: got %h required 0", snap1());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_flight();
    test_exit_right();
    test_offscreen_launch();
    test_stride();
    test_wrap_and_relaunch();
    test_abort();
    test_reset_mid_flight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
